// File: rtl/fadd_tree_accum.sv
// Vector accumulator behind the floating-point adder tree: sums the beats of each
// vector and queues the final sum with its beat count in a 2-entry output FIFO.
module fadd_tree_accum #(
  parameter int sig_width = 8,
  parameter int exp_width = 7,
  parameter int DATA_BIT  = sig_width + exp_width + 1,
  parameter int MAX_BEATS = 256,
  parameter int CNT_BIT   = $clog2(MAX_BEATS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_BIT-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic [DATA_BIT-1:0] out_data,
  output logic [CNT_BIT-1:0]  out_beats,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                err_clr,
  output logic                err_overrun,
  output logic                err_drop
);

  localparam int MW = sig_width + 1;
  localparam int XW = MW + 3;
  localparam logic [exp_width-1:0] EXP_MAX = '1;
  localparam logic [CNT_BIT-1:0]   MAX_CNT = CNT_BIT'(MAX_BEATS);

  // m is normalised (m[XW-1] set) with guard, round and sticky in the low three bits.
  function automatic logic [DATA_BIT-1:0] fp_round(input logic sgn, input int e,
                                                   input logic [XW-1:0] m,
                                                   input logic [2:0] rnd);
    logic           up;
    logic [sig_width:0] mr;
    int             ee;
    up = (rnd == 3'b000) ? (m[2] & (m[1] | m[0] | m[3])) : 1'b0;
    mr = {1'b0, m[XW-2:3]} + {{sig_width{1'b0}}, up};
    ee = mr[sig_width] ? e + 1 : e;
    if (ee <= 0)
      return '0;
    if (ee >= int'(EXP_MAX))
      return {sgn, EXP_MAX, {sig_width{1'b0}}};
    return {sgn, ee[exp_width-1:0], mr[sig_width-1:0]};
  endfunction

  // Denormal inputs and underflowing results flush to zero; exact cancellation gives +0.
  function automatic logic [DATA_BIT-1:0] fp_add(input logic [DATA_BIT-1:0] a,
                                                 input logic [DATA_BIT-1:0] b,
                                                 input logic [2:0] rnd);
    logic [DATA_BIT-1:0]  x, y;
    logic [exp_width-1:0] ex, ey, d;
    logic [XW-1:0]        ax, ay0, ay, mask;
    logic [XW:0]          s;
    logic                 lost, found;
    int                   e, lz;
    if (a[DATA_BIT-2:sig_width] == '0)
      return (b[DATA_BIT-2:sig_width] == '0) ? '0 : b;
    if (b[DATA_BIT-2:sig_width] == '0)
      return a;
    if (a[DATA_BIT-2:0] >= b[DATA_BIT-2:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex = x[DATA_BIT-2:sig_width];
    ey = y[DATA_BIT-2:sig_width];
    if (ex == EXP_MAX)
      return x;
    d   = ex - ey;
    ax  = {1'b1, x[sig_width-1:0], 3'b000};
    ay0 = {1'b1, y[sig_width-1:0], 3'b000};
    if (int'(d) >= XW) begin
      ay = {{(XW-1){1'b0}}, 1'b1};
    end else begin
      mask = ~({XW{1'b1}} << d);
      ay   = (ay0 >> d) | {{(XW-1){1'b0}}, |(ay0 & mask)};
    end
    if (x[DATA_BIT-1] == y[DATA_BIT-1])
      s = {1'b0, ax} + {1'b0, ay};
    else
      s = {1'b0, ax} - {1'b0, ay};
    if (s == '0)
      return '0;
    e = int'(ex);
    if (s[XW]) begin
      lost = s[0];
      s    = s >> 1;
      s[0] = s[0] | lost;
      e    = e + 1;
    end else begin
      lz    = 0;
      found = 1'b0;
      for (int i = XW - 1; i >= 0; i--) begin
        if (!found) begin
          if (s[i]) found = 1'b1;
          else      lz = lz + 1;
        end
      end
      s = s << lz;
      e = e - lz;
    end
    return fp_round(x[DATA_BIT-1], e, s[XW-1:0], rnd);
  endfunction

  logic [DATA_BIT-1:0] acc, sum, push_data;
  logic [CNT_BIT-1:0]  cnt, cnt_inc, push_beats;
  logic                push, pop, full, drop, overrun_set;
  logic [1:0]          fcnt;
  logic [DATA_BIT-1:0] tail_data;
  logic [CNT_BIT-1:0]  tail_beats;

  assign sum        = fp_add(acc, in_data, 3'b000);
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
  assign push       = in_last;
  assign push_data  = in_valid ? sum : acc;
  assign push_beats = in_valid ? cnt_inc : cnt;
  assign overrun_set = in_valid & ~in_last & (cnt == MAX_CNT);

  assign out_valid = (fcnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign full      = (fcnt == 2'd2);
  assign drop      = push & full & ~pop;

  // Accumulator: a last beat closes the vector so the next beat starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_last) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      acc <= sum;
      cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt <= 2'd0;
    end else if (push & ~pop & ~full) begin
      fcnt <= fcnt + 2'd1;
    end else if (pop & ~push) begin
      fcnt <= fcnt - 2'd1;
    end
  end

  // Head register drives the outputs directly, so it keeps the last popped value when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_beats  <= '0;
      tail_data  <= '0;
      tail_beats <= '0;
    end else if (push & pop) begin
      if (full) begin
        out_data   <= tail_data;
        out_beats  <= tail_beats;
        tail_data  <= push_data;
        tail_beats <= push_beats;
      end else begin
        out_data   <= push_data;
        out_beats  <= push_beats;
      end
    end else if (pop) begin
      if (full) begin
        out_data  <= tail_data;
        out_beats <= tail_beats;
      end
    end else if (push) begin
      if (fcnt == 2'd0) begin
        out_data  <= push_data;
        out_beats <= push_beats;
      end else if (fcnt == 2'd1) begin
        tail_data  <= push_data;
        tail_beats <= push_beats;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_overrun <= 1'b0;
      err_drop    <= 1'b0;
    end else begin
      err_overrun <= overrun_set | (err_overrun & ~err_clr);
      err_drop    <= drop | (err_drop & ~err_clr);
    end
  end

endmodule
